// File: rtl/addsub_pipe.sv
// Two-stage pipelined two's-complement adder/subtractor with valid/ready handshake,
// optional signed saturation and an internal accumulator operand.
module addsub_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             sat,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             co,
  output logic             oflow
);

  localparam int unsigned LO = WIDTH / 2;
  localparam int unsigned HI = WIDTH - LO;

  logic             s1_valid, s1_sat, s1_acc, s1_c_lo;
  logic [WIDTH-1:0] s1_opa, s1_opb;
  logic [LO-1:0]    s1_lo;
  logic             s2_valid;
  logic [WIDTH-1:0] acc;

  logic             s1_en, s2_en, in_fire, s1_move;
  logic [WIDTH-1:0] opa_in, opb_in, sum, z_next;
  logic [LO:0]      lo_full;
  logic [HI:0]      hi_full;
  logic             co_next, c_msb, of_next;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  // No acceptance of any kind while an accumulate op waits in s1: its write-back must land first.
  assign in_ready  = s1_en && !(s1_valid && s1_acc);
  assign in_fire   = in_valid && in_ready;
  assign s1_move   = s1_valid && s2_en;
  assign out_valid = s2_valid;

  always_comb begin
    opa_in  = acc_en ? acc : a;
    opb_in  = sub ? ~b : b;
    lo_full = {1'b0, opa_in[LO-1:0]} + {1'b0, opb_in[LO-1:0]} + {{LO{1'b0}}, sub};
    hi_full = {1'b0, s1_opa[WIDTH-1:LO]} + {1'b0, s1_opb[WIDTH-1:LO]} + {{HI{1'b0}}, s1_c_lo};
    sum     = {hi_full[HI-1:0], s1_lo};
    co_next = hi_full[HI];
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    c_msb   = sum[WIDTH-1] ^ s1_opa[WIDTH-1] ^ s1_opb[WIDTH-1];
    of_next = c_msb ^ co_next;
    z_next  = sum;
    if (s1_sat && of_next) begin
      z_next = s1_opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_acc   <= 1'b0;
      s1_c_lo  <= 1'b0;
      s1_opa   <= '0;
      s1_opb   <= '0;
      s1_lo    <= '0;
      s2_valid <= 1'b0;
      z        <= '0;
      co       <= 1'b0;
      oflow    <= 1'b0;
      acc      <= '0;
    end else begin
      if (s1_en) s1_valid <= in_fire;
      if (in_fire) begin
        s1_opa  <= opa_in;
        s1_opb  <= opb_in;
        s1_sat  <= sat;
        s1_acc  <= acc_en;
        s1_lo   <= lo_full[LO-1:0];
        s1_c_lo <= lo_full[LO];
      end
      if (s2_en) s2_valid <= s1_valid;
      if (s1_move) begin
        z     <= z_next;
        co    <= co_next;
        oflow <= of_next;
      end
      if (acc_clr) begin
        acc <= '0;
      end else if (s1_move && s1_acc) begin
        acc <= z_next;
      end
    end
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, two-stage pipelined two's-complement adder/subtractor with valid/ready handshake, optional signed saturation, and an internal accumulator mode. It is the successor to the fixed 5-bit cell-level add/subtractor. It sits between operand producers (FIFO read side, counters) and result consumers, and reports carry-out and signed overflow per transaction.

## Interface
- WIDTH, 8, operand/result width; legal values are ≥ 2. LO = WIDTH/2 (integer division) and HI = WIDTH − LO.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  block accepts a transaction this cycle.
- sub  in  1  0 = a+b; 1 = a−b, computed as a + ~b + 1.
- sat  in  1  1 = saturate z on signed overflow.
- acc_en  in  1  1 = use the accumulator in place of a; the final z is written back to the accumulator.
- acc_clr  in  1  synchronously clears the accumulator; independent of the handshake.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- z  out  WIDTH  result.
- co  out  1  raw carry out of the MSB. For subtract, 1 = no borrow.
- oflow  out  1  signed overflow; always the pre-saturation value.

## Operation
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (s1) registers, on input transfer:
  - opA (acc if acc_en, else a) and ~b if sub, else b;
  - sub, sat, acc_en;
  - LO-bit low sum of opA[LO-1:0] + b'[LO-1:0] + sub, and its carry c_lo.
- Stage 2 (s2) registers, on s1→s2 move:
  - the HI-bit high sum using carry-in c_lo;
  - co = carry out of bit WIDTH−1;
  - oflow = carry into bit WIDTH−1 XOR co.
- Saturation applies when sat && oflow:
  - z = 0111…1 if opA[WIDTH−1] = 0;
  - z = 1000…0 if opA[WIDTH−1] = 1.
  - Otherwise z is the raw sum modulo 2^WIDTH.
- Pipeline enables:
  - s2_en = !s2_valid || out_ready;
  - s1_en = !s1_valid || s2_en (bubbles collapse).
- in_ready = s1_en && !(s1_valid && s1_acc).
  - This is the accumulator interlock: no new transaction of any kind is accepted while an acc_en transaction sits in s1.
  - in_ready does not depend on in_valid or on any other input operand.
- Accumulator:
  - Internal WIDTH-bit register acc.
  - Loaded with the final (post-saturation) z on the same edge that an acc_en transaction moves s1→s2.
  - acc_clr = 1 sets acc to 0 on that edge. acc_clr has priority over a simultaneous write-back.
  - acc_clr does not affect transactions already in flight; an in-flight opA keeps the old value.
- z, co and oflow hold their values while out_valid && !out_ready.
- A non-acc transaction never reads or modifies acc.

## Timing
- Reset (rst_n = 0 at an edge):
  - s1_valid, s2_valid, out_valid = 0;
  - z = 0, co = 0, oflow = 0, acc = 0.
  - In-flight transactions are discarded.
  - in_ready is 1 in the first cycle after reset.
- Latency: a transaction accepted at edge t has out_valid = 1 after edge t+1 when unstalled (2 register stages).
- Throughput:
  - 1 transaction/cycle for non-acc traffic.
  - Back-to-back acc_en transactions run at 1 per 2 cycles. The second transaction reads acc already updated by the first.
- Backpressure: with out_ready held at 0, exactly 2 transactions are accepted, then in_ready = 0. Order is preserved and no transaction is lost or duplicated.
- Simultaneous events:
  - Output and input transfers in the same cycle with both stages full: the pipeline shifts and in_ready stays 1.
  - acc_clr in the same cycle as a write-back: acc = 0.
- Wrap-around: unsigned overflow wraps modulo 2^WIDTH. co reports it and oflow is unaffected.

## Test plan
- WIDTH=5, sat=0:
  - 7+5 → z=01100, co=0, oflow=0;
  - 12+5 → z=10001, co=0, oflow=1;
  - the 12+5 result appears exactly 2 cycles after acceptance.
- WIDTH=5, sub=1:
  - 5−3 → z=00010, co=1, oflow=0;
  - 3−5 → z=11110, co=0;
  - −16−1 with sat=1 → z=10000, oflow=1.
- WIDTH=5, sat=1: 12+5 → z=01111, oflow=1; −12+(−8) → z=10000.
- Accumulate:
  - acc_clr pulse, then three acc_en adds of b=3 offered every cycle → z=3, 6, 9;
  - in_ready low for one cycle after each acceptance;
  - acc=9 at the end.
- Backpressure:
  - out_ready=0 while 4 ops are offered → 2 accepted, then in_ready=0;
  - release → 4 results in order, with z stable while stalled.
- Reset mid-operation: rst_n=0 for 1 cycle with both stages full and acc=9 → out_valid=0, acc=0; the next op 1+1 yields z=2.
